// File: rtl/fsm_rd_094_chk.sv
// Initiator/checker for the fsm_rd_094 frame generator: releases it via ptext[1],
// checks the 7-symbol rtext frame and keeps frame/error counters. Optional macro: FSM_RD_094_CHK_AUTO_EN.
module fsm_rd_094_chk #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
`ifdef FSM_RD_094_CHK_AUTO_EN
  input  logic             auto_mode,
`endif
  input  logic [2:0]       rtext,
  output logic [1:0]       ptext,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_E4   = 3'd2,
    S_E5   = 3'd3,
    S_E6   = 3'd4,
    S_E7   = 3'd5,
    S_E1   = 3'd6
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [2:0]       exp_sym;
  logic             auto_go;

`ifdef FSM_RD_094_CHK_AUTO_EN
  assign auto_go = auto_mode;
`else
  assign auto_go = 1'b0;
`endif

  // Symbol each frame state must see during its single cycle of occupancy.
  always_comb begin
    exp_sym = 3'b000;
    case (state_q)
      S_E6, S_E7: exp_sym = 3'b100;
      default:    exp_sym = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARM;
          tcnt_d  = 8'd0;
        end
      end
      S_ARM: begin
        // Header match wins over a timeout landing on the same sample.
        if (rtext == 3'b010) begin
          state_d = S_E4;
        end else if (rtext == 3'b000) begin
          if (tcnt_q == TLAST) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end else begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
      end
      S_E4, S_E5, S_E6, S_E7, S_E1: begin
        if (rtext != exp_sym) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else begin
          case (state_q)
            S_E4:    state_d = S_E5;
            S_E5:    state_d = S_E6;
            S_E6:    state_d = S_E7;
            S_E7:    state_d = S_E1;
            default: begin
              state_d     = auto_go ? S_ARM : S_IDLE;
              tcnt_d      = 8'd0;
              done_d      = 1'b1;
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      tcnt_q      <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      frame_cnt_q <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ptext     = {state_q == S_ARM, 1'b0};
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fsm_rd_094_chk.md
Name: fsm_rd_094_chk

Overview:
- Initiator/checker for the fsm_rd_094 frame generator; sits on the opposite side of the ptext/rtext interface.
- Drives the ptext[1] request that releases the generator from its wait loop.
- Checks the returned 7-symbol rtext frame cycle by cycle, then reports done or error and keeps frame/error counters.
- Used in bring-up and self-test of the generator.

Parameters:
TIMEOUT, 8, max cycles in ARM waiting for the 010 header before a timeout error (legal range 2..255)
CNT_W, 16, width of frame_cnt

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to check one frame; ignored unless in IDLE
rtext  input  3  symbol stream from the generator, sampled every rising edge
ptext  output  2  request to the generator; [1]=release, [0]=0 (see Optional Feature)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a full frame matches
err  output  1  one-cycle pulse on any error
err_code  output  2  cause of last error, held until the next err; 01 timeout, 10 frame mismatch, 11 unexpected symbol while armed
frame_cnt  output  CNT_W  count of good frames; wraps at 2^CNT_W
err_cnt  output  8  count of errors; saturates at 255

Behaviour:
- Reset (async, RST=1): state IDLE, ptext=00, busy=0, done=0, err=0, err_code=00, frame_cnt=0, err_cnt=0, timeout counter=0.
- Reset mid-frame: abort immediately; no done or err is produced.
- Moore machine. ptext and busy are decoded from the state register only. done, err, err_code and the counters are registered.
- States: IDLE, ARM, E4, E5, E6, E7, E1.
- IDLE:
  - start=1 -> ARM; clear the timeout counter.
- ARM (ptext[1]=1):
  - rtext==010 -> E4.
  - rtext==000 and tcnt==TIMEOUT-1 -> IDLE; err=1, err_code=01.
  - rtext==000 otherwise -> stay; tcnt increments.
  - Any other rtext value -> IDLE; err=1, err_code=11.
  - Priority: a 010 header seen on the same cycle the timeout would fire takes precedence; that cycle is treated as a match.
- Expected symbols: E4=000, E5=000, E6=100, E7=100, E1=000.
  - Each state checks its expected symbol in the single cycle it is occupied.
  - Match advances E4->E5->E6->E7->E1.
  - Any mismatch -> IDLE; err=1, err_code=10.
- E1 match -> IDLE; done=1, frame_cnt+1.
- Pulse timing: done and err assert in the cycle after the deciding sample.
- Header latency: 010 arrives 1 cycle after ARM entry if the generator waits in st2/st2_n, or 2 cycles if it is in st1.
- ptext[1] drops in the cycle after the 010 header is sampled, because the state has left ARM.
- start asserted while busy: ignored, with no queueing.
- err_cnt increments on every err pulse until it reaches 255.
- done and err never assert in the same cycle.

Optional Feature:
- Macro: FSM_RD_094_CHK_AUTO_EN.
- Defined: adds input auto_mode (1 bit).
  - When auto_mode=1, a successful E1 goes directly to ARM instead of IDLE; done still pulses and the timeout counter is cleared.
  - busy stays high across back-to-back frames.
  - Any error always returns to IDLE.
  - auto_mode=0 behaves exactly as the base design.
- Undefined: no auto_mode port; E1 always returns to IDLE.
- ptext[0] stays 0 in both builds.

Test Plan:
- Golden frame: RST, then start while the generator waits in st2; rtext = 010,000,000,100,100,000 -> done one cycle after the final 000, frame_cnt=1, err=0, ptext[1] high exactly 1 cycle.
- Timeout: TIMEOUT=8, start, hold rtext=000 -> err at ARM cycle 8, err_code=01, err_cnt=1, back in IDLE (busy=0).
- Mismatch: feed 010,000,000,100,000 -> err on the E7 check with err_code=10; frame_cnt unchanged.
- Unexpected symbol: start, then rtext=100 while in ARM -> err, err_code=11; a subsequent golden frame gives done, and err_code still reads 11.
- Mid-frame reset and ignored start: assert RST during E6 -> all outputs 0, no pulse; separately, start pulses during E5 have no effect and exactly one done results.
- Auto mode (macro defined, auto_mode=1), connected to the real generator: 3 consecutive frames -> 3 done pulses spaced 7 cycles apart, busy continuously 1, frame_cnt=3; counters checked at CNT_W=2 wrap (4 frames -> frame_cnt=0).
